// File: rtl/bram_client_pkg.sv
// Shared defaults, credit-width helper and FIFO safety assertions for the
// block-RAM read client.

`ifndef BRAM_CLIENT_PKG_MACROS
`define BRAM_CLIENT_PKG_MACROS
`define BRC_ASSERT_NO_OVERFLOW(clk, rst, push, full) \
    assert property (@(posedge clk) disable iff (rst) !((push) && (full)))
`define BRC_ASSERT_NO_UNDERFLOW(clk, rst, pop, empty) \
    assert property (@(posedge clk) disable iff (rst) !((pop) && (empty)))
`endif

package bram_client_pkg;

    localparam int DEFAULT_DATA_SIZE = 32;
    localparam int DEFAULT_ADDR_SIZE = 9;
    localparam int DEFAULT_RSP_DEPTH = 4;

    // Width able to hold every value 0..depth, i.e. a full credit count.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Register-based synchronous response FIFO: push/pop, occupancy and a head
// word read straight from storage (no bypass, so data is always registered).

module bram_rsp_fifo
    import bram_client_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int DEPTH     = DEFAULT_RSP_DEPTH
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           push,
    input  logic [DATA_SIZE-1:0]           push_data,
    input  logic                           pop,
    output logic [credit_width(DEPTH)-1:0] occ,
    output logic [DATA_SIZE-1:0]           head,
    output logic                           empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = credit_width(DEPTH);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [OCC_W-1:0]     count;
    logic                 full;

    // NOTE: the storage is only a few registers, so it is reset along with the
    // pointers; that makes the head word read as zero straight after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign occ   = count;
    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == OCC_W'(DEPTH));

    a_no_overflow:  `BRC_ASSERT_NO_OVERFLOW(CLK, RST, push, full);
    a_no_underflow: `BRC_ASSERT_NO_UNDERFLOW(CLK, RST, pop, empty);

endmodule

// File: rtl/bram_read_client.sv
// Initiator-side block-RAM controller: credit-gated read issue with a response
// FIFO for the one-cycle read data, plus write pass-through with hazard stall.

module bram_read_client
    import bram_client_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int RSP_DEPTH = DEFAULT_RSP_DEPTH
) (
    input  logic                 CLK,
    input  logic                 RST,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_SIZE-1:0] req_addr,

    input  logic                 wr_valid,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_SIZE-1:0] rsp_data,

    output logic                 ram_readEnable,
    output logic [ADDR_SIZE-1:0] ram_readAddr,
    input  logic [DATA_SIZE-1:0] ram_readData,
    output logic                 ram_writeEnable,
    output logic [ADDR_SIZE-1:0] ram_writeAddr,
    output logic [DATA_SIZE-1:0] ram_writeData
);

    localparam int OCC_W = credit_width(RSP_DEPTH);

    logic [OCC_W-1:0]     occ;
    logic [OCC_W:0]       credits;
    logic                 inflight;
    logic [ADDR_SIZE-1:0] last_addr;
    logic                 hazard;
    logic                 issue;
    logic                 pop;
    logic                 empty;

    // Outstanding reads = words already queued plus the one on the RAM bus.
    // Depends only on registers and the request/write inputs, never rsp_ready.
    assign credits   = {1'b0, occ} + (OCC_W + 1)'(inflight);
    assign hazard    = wr_valid && (wr_addr == req_addr);
    assign req_ready = !RST && (credits < (OCC_W + 1)'(RSP_DEPTH)) && !hazard;
    assign issue     = req_valid && req_ready;

    assign ram_readEnable  = issue;
    assign ram_readAddr    = issue ? req_addr : last_addr;
    assign ram_writeEnable = wr_valid && !RST;
    assign ram_writeAddr   = wr_addr;
    assign ram_writeData   = wr_data;

    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
        end
    end

    // NOTE: the held read address carries no reset; it is only observed as the
    // idle value of ram_readAddr, and an issue always overwrites it first.
    always_ff @(posedge CLK) begin
        if (issue) begin
            last_addr <= req_addr;
        end
    end

    assign rsp_valid = !empty;
    assign pop       = rsp_valid && rsp_ready;

    bram_rsp_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (RSP_DEPTH)
    ) u_rsp_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (inflight),
        .push_data (ram_readData),
        .pop       (pop),
        .occ       (occ),
        .head      (rsp_data),
        .empty     (empty)
    );

endmodule

// File: tb/tb_bram_read_client.sv
// Self-checking bench for bram_read_client: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.

module tb_bram_read_client;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 4;

    logic          CLK;
    logic          RST;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          ram_readEnable;
    logic [AW-1:0] ram_readAddr;
    logic [DW-1:0] ram_readData;
    logic          ram_writeEnable;
    logic [AW-1:0] ram_writeAddr;
    logic [DW-1:0] ram_writeData;

    bram_read_client #(
        .DATA_SIZE (DW),
        .ADDR_SIZE (AW),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .wr_valid        (wr_valid),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .ram_readEnable  (ram_readEnable),
        .ram_readAddr    (ram_readAddr),
        .ram_readData    (ram_readData),
        .ram_writeEnable (ram_writeEnable),
        .ram_writeAddr   (ram_writeAddr),
        .ram_writeData   (ram_writeData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM primitive: registered read, read-before-write on the same edge.
    logic [DW-1:0] ram [2**AW];
    always @(posedge CLK) begin
        if (ram_readEnable)  ram_readData <= ram[ram_readAddr];
        if (ram_writeEnable) ram[ram_writeAddr] <= ram_writeData;
    end

    typedef struct {
        bit            rst;
        bit            req_valid;
        logic [AW-1:0] req_addr;
        bit            wr_valid;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        bit            rsp_ready;
        bit            exp_ready;
        bit            exp_valid;
        logic [DW-1:0] exp_data;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } pend_t;

    // Reference model: every accepted read is a queue entry holding the memory
    // word at acceptance time; it becomes visible two cycles later.
    pend_t         pend_q[$];
    logic [DW-1:0] ref_mem [2**AW];
    logic [AW-1:0] ref_last_addr;
    bit            addr_known;
    bit            after_rst;
    int            cyc;

    int n_vec;
    int n_bad;
    int dut_accepts;
    int rsp_count;
    int first_rsp;
    int last_rsp;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit rv, input int ra, input bit wv, input int wa,
                                input logic [DW-1:0] wd, input bit rr,
                                input bit er, input bit ev, input logic [DW-1:0] ed);
        vec_t v;
        v.rst       = 1'b0;
        v.req_valid = rv;
        v.req_addr  = AW'(ra);
        v.wr_valid  = wv;
        v.wr_addr   = AW'(wa);
        v.wr_data   = wd;
        v.rsp_ready = rr;
        v.exp_ready = er;
        v.exp_valid = ev;
        v.exp_data  = ed;
        return v;
    endfunction

    task automatic step(input vec_t v, input bit use_tab);
        bit            exp_ready;
        bit            exp_valid;
        bit            exp_issue;
        logic [DW-1:0] exp_data;
        RST       = v.rst;
        req_valid = v.req_valid;
        req_addr  = v.req_addr;
        wr_valid  = v.wr_valid;
        wr_addr   = v.wr_addr;
        wr_data   = v.wr_data;
        rsp_ready = v.rsp_ready;
        @(negedge CLK);

        exp_valid = (pend_q.size() > 0) && (pend_q[0].cyc + 2 <= cyc);
        exp_data  = exp_valid ? pend_q[0].data : '0;
        exp_ready = !v.rst && (pend_q.size() < DEPTH) && !(v.wr_valid && v.wr_addr == v.req_addr);
        exp_issue = v.req_valid && exp_ready;

        check("req_ready", req_ready, exp_ready);
        check("rsp_valid", rsp_valid, exp_valid);
        if (exp_valid || after_rst) check("rsp_data", rsp_data, exp_data);
        check("ram_readEnable", ram_readEnable, exp_issue);
        if (exp_issue) begin
            ref_last_addr = v.req_addr;
            addr_known    = 1'b1;
        end
        if (addr_known) check("ram_readAddr", ram_readAddr, ref_last_addr);
        check("ram_writeEnable", ram_writeEnable, v.wr_valid && !v.rst);
        if (v.wr_valid && !v.rst) begin
            check("ram_writeAddr", ram_writeAddr, v.wr_addr);
            check("ram_writeData", ram_writeData, v.wr_data);
        end
        if (use_tab) begin
            check("tab_req_ready", req_ready, v.exp_ready);
            check("tab_rsp_valid", rsp_valid, v.exp_valid);
            if (v.exp_valid) check("tab_rsp_data", rsp_data, v.exp_data);
        end

        if (req_valid && req_ready) dut_accepts++;
        if (rsp_valid && rsp_ready) begin
            if (rsp_count == 0) first_rsp = cyc;
            last_rsp = cyc;
            rsp_count++;
        end

        if (v.rst) begin
            pend_q.delete();
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (exp_valid && v.rsp_ready) void'(pend_q.pop_front());
            if (exp_issue) pend_q.push_back('{ref_mem[v.req_addr], cyc});
            if (v.wr_valid) ref_mem[v.wr_addr] = v.wr_data;
        end
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit rst, input bit rv, input int ra, input bit wv,
                         input int wa, input logic [DW-1:0] wd, input bit rr);
        vec_t v;
        v     = mk(rv, ra, wv, wa, wd, rr, 1'b0, 1'b0, '0);
        v.rst = rst;
        step(v, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab [16];
        int   base;

        for (int i = 0; i < 2**AW; i++) begin
            ram[i]     = 32'hC000_0000 | DW'(i);
            ref_mem[i] = 32'hC000_0000 | DW'(i);
        end
        ram[5]     = 32'hA5A5_0005;
        ref_mem[5] = 32'hA5A5_0005;
        ram[7]     = 32'h0;
        ref_mem[7] = 32'h0;

        n_vec = 0; n_bad = 0; cyc = 0; dut_accepts = 0; rsp_count = 0;
        first_rsp = 0; last_rsp = 0; addr_known = 1'b0;
        RST = 1'b1; req_valid = 1'b0; req_addr = '0; wr_valid = 1'b0;
        wr_addr = '0; wr_data = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        after_rst = 1'b1;

        // rv  ra  wv wa wd             rr  ready valid data
        tab[0]  = mk(0, 0, 0, 0, 32'h0,          1, 1, 0, 32'h0);
        tab[1]  = mk(1, 5, 0, 0, 32'h0,          1, 1, 0, 32'h0);
        tab[2]  = mk(0, 0, 0, 0, 32'h0,          1, 1, 0, 32'h0);
        tab[3]  = mk(0, 0, 0, 0, 32'h0,          1, 1, 1, 32'hA5A5_0005);
        tab[4]  = mk(0, 0, 0, 0, 32'h0,          1, 1, 0, 32'h0);
        tab[5]  = mk(1, 7, 1, 7, 32'hDEAD_BEEF,  1, 0, 0, 32'h0);
        tab[6]  = mk(1, 7, 0, 0, 32'h0,          1, 1, 0, 32'h0);
        tab[7]  = mk(0, 0, 0, 0, 32'h0,          1, 1, 0, 32'h0);
        tab[8]  = mk(0, 0, 0, 0, 32'h0,          1, 1, 1, 32'hDEAD_BEEF);
        tab[9]  = mk(1, 7, 0, 0, 32'h0,          1, 1, 0, 32'h0);
        tab[10] = mk(0, 0, 1, 7, 32'h1234_5678,  1, 1, 0, 32'h0);
        tab[11] = mk(0, 0, 0, 0, 32'h0,          1, 1, 1, 32'hDEAD_BEEF);
        tab[12] = mk(0, 0, 0, 0, 32'h0,          1, 1, 0, 32'h0);
        tab[13] = mk(1, 7, 0, 0, 32'h0,          1, 1, 0, 32'h0);
        tab[14] = mk(0, 0, 0, 0, 32'h0,          1, 1, 0, 32'h0);
        tab[15] = mk(0, 0, 0, 0, 32'h0,          1, 1, 1, 32'h1234_5678);
        for (int i = 0; i < 16; i++) step(tab[i], 1'b1);

        // Back-to-back reads of 0..15 with the consumer always ready.
        base = dut_accepts;
        rsp_count = 0;
        for (int i = 0; i < 16; i++) drive(0, 1, i, 0, 0, '0, 1);
        repeat (4) drive(0, 0, 0, 0, 0, '0, 1);
        check("b2b_accepts", dut_accepts - base, 16);
        check("b2b_responses", rsp_count, 16);
        check("b2b_gapless", last_rsp - first_rsp + 1, 16);

        // Backpressure: credits stop issue at RSP_DEPTH, then drain.
        base = dut_accepts;
        for (int i = 0; i < 8; i++) drive(0, 1, 16 + i, 0, 0, '0, 0);
        check("bp_accepts", dut_accepts - base, DEPTH);
        rsp_count = 0;
        repeat (6) drive(0, 0, 0, 0, 0, '0, 1);
        check("bp_drained", rsp_count, DEPTH);

        // Reset with three reads outstanding: nothing may surface afterwards.
        for (int i = 0; i < 3; i++) drive(0, 1, 20 + i, 0, 0, '0, 0);
        drive(1, 0, 0, 0, 0, '0, 1);
        rsp_count = 0;
        repeat (5) drive(0, 0, 0, 0, 0, '0, 1);
        check("rst_no_stray", rsp_count, 0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 99) == 0,
                  ($urandom % 10) < 7, $urandom_range(0, 15),
                  ($urandom % 10) < 4, $urandom_range(0, 15), $urandom,
                  ($urandom % 4) != 0);
        end
        repeat (8) drive(0, 0, 0, 0, 0, '0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_read_client.md
Name: bram_read_client

Overview:
- Initiator-side controller for the single-port-read / single-port-write block RAM primitive.
- Accepts valid/ready read requests and issues them to the RAM read port. The RAM's fixed one-cycle read data is captured into a small response FIFO.
- Credits guarantee no returned data is ever dropped. Writes pass through with a read-after-write hazard check.
- Sits between Bluespec-side request/response channels and the RAM instance.

Parameters:
- DATA_SIZE, 32, RAM word width.
- ADDR_SIZE, 9, RAM address width.
- RSP_DEPTH, 4, response FIFO entries; power of two, at least 2. At least 3 is needed for one read per cycle.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  read request present.
- req_ready  out  1  read request accepted this cycle when req_valid is also high.
- req_addr  in  ADDR_SIZE  read address.
- wr_valid  in  1  write request; always accepted outside reset.
- wr_addr  in  ADDR_SIZE  write address.
- wr_data  in  DATA_SIZE  write data.
- rsp_valid  out  1  response data available.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  DATA_SIZE  head-of-FIFO read data.
- ram_readEnable  out  1  to RAM readEnable.
- ram_readAddr  out  ADDR_SIZE  to RAM readAddr.
- ram_readData  in  DATA_SIZE  from RAM readData; valid the cycle after the address is presented.
- ram_writeEnable  out  1  to RAM writeEnable.
- ram_writeAddr  out  ADDR_SIZE  to RAM writeAddr.
- ram_writeData  out  DATA_SIZE  to RAM writeData.

Behaviour:
- Reset, sampled on posedge with RST=1:
  - FIFO emptied; inflight flag cleared.
  - rsp_valid=0 and rsp_data=0 from the next cycle.
  - While RST=1: req_ready=0, ram_writeEnable=0, ram_readEnable=0.
- Credit count is occ + inflight, where occ is FIFO occupancy and inflight is a 1-bit register.
- req_ready=1 iff all of the following hold:
  - RST=0;
  - occ + inflight < RSP_DEPTH;
  - no hazard, i.e. NOT (wr_valid && wr_addr==req_addr).
- req_ready has no combinational path from rsp_ready.
- Issue (req_valid && req_ready in cycle t):
  - ram_readEnable=1 and ram_readAddr=req_addr, driven combinationally in cycle t.
  - inflight<=1.
- When no read issues: ram_readAddr holds its last issued value; ram_readEnable=0.
- Capture: if inflight=1 in cycle t+1, ram_readData is pushed into the FIFO at the end of t+1. inflight<=0 unless a new issue occurs in t+1.
- Latency: rsp_valid rises in cycle t+2; rsp_data is registered from FIFO storage.
- Pop: rsp_valid && rsp_ready removes the head.
  - Push and pop in the same cycle leave occ unchanged.
  - Push into a full FIFO is impossible by credit construction; assert this in simulation.
- Writes: ram_writeEnable=wr_valid&&!RST, ram_writeAddr=wr_addr, ram_writeData=wr_data, all combinational, no latency.
- Hazard: a same-address write and read in the same cycle stalls the read one cycle. The read then returns the new data.
  - A write in cycle t+1 to the address read in cycle t returns the old data; read-before-write order is preserved.
- Ordering: responses are returned strictly in request order.
- Reset mid-operation: in-flight read data arriving in the cycle after reset is discarded (inflight is already 0). Queued responses are lost.
- Wrap-around: FIFO read/write pointers are log2(RSP_DEPTH) bits with natural wrap. occ width is $clog2(RSP_DEPTH+1).
- The RAM's gated-clock input is not driven by this block.

Decomposition:
- Shared package bram_client_pkg:
  - default DATA_SIZE/ADDR_SIZE;
  - credit-width function clog2(RSP_DEPTH+1);
  - assertion macros for FIFO overflow/underflow.
- One sub-module, bram_rsp_fifo: register-based synchronous FIFO with push/pop/occ/head. It has no bypass, so data is always registered.

Test Plan:
- Reset release, RAM preloaded ram[5]=32'hA5A5_0005; one read of addr 5 in cycle 10, rsp_ready=1 -> rsp_valid=1 in cycle 12 only, rsp_data=32'hA5A5_0005; req_ready=1 throughout.
- Back-to-back reads of addrs 0..15, rsp_ready=1, RSP_DEPTH=4 -> one request accepted per cycle, 16 responses in order, no gaps after the first.
- Reads with rsp_ready=0 -> exactly 4 requests accepted, then req_ready=0. Raise rsp_ready -> 4 responses drain, and req_ready returns 1 the cycle after the first pop.
- Write 32'hDEAD_BEEF and read, both at addr 7, same cycle (old value 0) -> read stalled one cycle (req_ready=0); response equals 32'hDEAD_BEEF.
- Read addr 7 at cycle t, write 32'h1234_5678 to addr 7 at cycle t+1 -> response carries the old value.
- 3 reads in flight, RST=1 for one cycle -> rsp_valid=0 the next cycle, FIFO empty, no stray response after reset, req_ready=1 once RST=0.
